i2c_write_arbiter: RTL and testbench
====================================

Name: i2c_write_arbiter

Overview:
- Shares the single I2C write master between NUM_REQ requesters using round-robin arbitration.
- Latches the winner's device address, register address and write data, then drives the master's enable.
- Waits for the master's done flag, acknowledges the requester, and enforces a bus-free gap before the next grant.
- Sits between the system requesters and the I2C master at the top level.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- GAP_CYCLES, 16, idle clk cycles between transactions (>=1).
- TIMEOUT_CYCLES, 65535, clk cycles allowed for i_done_flag (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-high (asserted = 1).
- i_req  in  NUM_REQ  per-requester request level; held until o_ack.
- i_dev_addr  in  7*NUM_REQ  packed 7-bit device addresses; requester k uses bits [7k+6:7k].
- i_data_addr  in  8*NUM_REQ  packed register addresses.
- i_wdata  in  8*NUM_REQ  packed write data.
- o_grant  out  NUM_REQ  one-hot; identifies the requester currently owning the master.
- o_ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- o_busy  out  1  high in any state other than IDLE.
- o_i2c_en  out  1  master enable.
- o_device_addr  out  7  to master.
- o_data_addr  out  8  to master.
- o_write_data  out  8  to master.
- i_done_flag  in  1  master completion.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = 0 (requester 0 highest priority); gap counter 0. Reset takes effect in any state, including mid-transaction. o_i2c_en drops the next cycle, and no o_ack is issued for the aborted transaction.
- IDLE: if any i_req bit is set, select the first set bit at or after the pointer, wrapping modulo NUM_REQ. In the same cycle, latch that requester's three fields into output registers, set o_grant one-hot, and go to XFER.
- XFER:
  - o_i2c_en = 1 from the first XFER cycle; request-to-enable latency is 1 cycle.
  - The address/data outputs hold stable and are not re-sampled, even if requester inputs change.
  - On i_done_flag = 1, go to DONE with o_i2c_en = 0 in that DONE cycle.
- DONE (1 cycle):
  - o_ack[granted] = 1.
  - The pointer advances to granted+1 mod NUM_REQ.
  - o_grant is cleared at exit, and the gap counter loads GAP_CYCLES-1.
  - Go to GAP.
- GAP: decrement the counter each cycle. At 0, go to IDLE. Requests are ignored during GAP.
- o_busy = 1 in XFER, DONE and GAP.
- Boundaries:
  - A requester that deasserts i_req in XFER is still served and acked.
  - A requester that keeps i_req high after o_ack is treated as a new request. Round-robin ensures another pending requester is served first.
  - A single active requester gets back-to-back service separated by GAP_CYCLES+2 cycles.
  - i_done_flag outside XFER is ignored.
  - Simultaneous requests in IDLE are resolved purely by the pointer.

Optional Feature:
- Macro I2C_ARB_TIMEOUT_EN.
- When defined:
  - Adds output o_timeout (1 bit, reset 0) and a 16-bit cycle counter cleared on entry to XFER.
  - If the counter reaches TIMEOUT_CYCLES while in XFER without i_done_flag, go to DONE: o_ack still pulses, o_timeout pulses high for that same cycle, o_i2c_en drops, and the pointer advances.
- When not defined: no counter and no o_timeout port; XFER waits indefinitely.

Decomposition:
- Package i2c_arb_pkg holds:
  - state encoding constants (IDLE=0, XFER=1, DONE=2, GAP=3);
  - field widths DEV_ADDR_W=7, DATA_W=8.
- One natural sub-module: i2c_rr_picker (combinational round-robin selector: inputs req vector and pointer; outputs one-hot grant and index).

Test Plan:
- Single request: requester 0 asserts req with dev 0x50, reg 0x10, data 0xA5.
  - o_i2c_en rises 1 cycle later and the master fields equal those values.
  - With done pulsed 20 cycles later, o_ack[0] pulses in the next cycle and o_busy falls after 16 gap cycles.
- Contention: requesters 0 and 1 request together and hold.
  - Grant order is 0, 1, 0, 1 over four transactions, with each o_ack on the correct bit.
- Input stability: change i_wdata[0] to 0x3C mid-XFER.
  - o_write_data stays 0xA5 until DONE.
- Reset mid-transaction: assert rst_n in XFER.
  - Next cycle: all outputs 0, no ack, and pointer back at 0.
- Stray done: pulse i_done_flag while in IDLE or GAP.
  - No state change and no ack.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100: never assert done.
  - o_timeout and o_ack pulse together at cycle 100 of XFER, and the next requester is granted after the gap.

Source files
------------

// File: rtl/i2c_write_arbiter_pkg.sv
// Shared types and widths for the I2C write arbiter.
package i2c_arb_pkg;

  localparam int DEV_ADDR_W = 7;
  localparam int DATA_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/i2c_write_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at or after the
// pointer, wrapping modulo NUM_REQ.
module i2c_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  // Priority scan starting at the pointer.
  always_comb begin
    int c;
    c       = 0;
    o_grant = {NUM_REQ{1'b0}};
    o_idx   = {IDX_W{1'b0}};
    o_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = int'(i_ptr) + i;
      c = (c >= NUM_REQ) ? c - NUM_REQ : c;
      if (!o_valid && i_req[c]) begin
        o_valid    = 1'b1;
        o_idx      = IDX_W'(c);
        o_grant[c] = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/i2c_write_arbiter.sv
// Round-robin arbiter sharing one I2C write master between NUM_REQ requesters.
// Optional transfer timeout enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_write_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [DEV_ADDR_W*NUM_REQ-1:0] i_dev_addr,
  input  logic [DATA_W*NUM_REQ-1:0]    i_data_addr,
  input  logic [DATA_W*NUM_REQ-1:0]    i_wdata,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic [NUM_REQ-1:0]           o_ack,
  output logic                         o_busy,
  output logic                         o_i2c_en,
  output logic [DEV_ADDR_W-1:0]        o_device_addr,
  output logic [DATA_W-1:0]            o_data_addr,
  output logic [DATA_W-1:0]            o_write_data,
`ifdef I2C_ARB_TIMEOUT_EN
  output logic                         o_timeout,
`endif
  input  logic                         i_done_flag
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [IDX_W-1:0]      r_ptr;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_pick_idx;
  logic [NUM_REQ-1:0]    w_pick_grant;
  logic                  w_pick_valid;
  logic [NUM_REQ-1:0]    r_grant;
  logic [NUM_REQ-1:0]    r_ack;
  logic                  r_busy;
  logic                  r_i2c_en;
  logic [DEV_ADDR_W-1:0] r_dev;
  logic [DATA_W-1:0]     r_reg;
  logic [DATA_W-1:0]     r_wdata;
  logic [GAP_W-1:0]      r_gap;
  logic                  w_tmo;
  logic                  w_xfer_end;

  i2c_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        r_timeout;

  assign w_tmo     = (r_state == ST_XFER) && (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign o_timeout = r_timeout;

  // Counts XFER cycles; cleared whenever a new transfer is granted.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_tmo_cnt <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_tmo_cnt <= 16'd0;
      end else if (r_state == ST_XFER) begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
        r_timeout <= w_tmo && !i_done_flag;
      end else begin
        r_tmo_cnt <= r_tmo_cnt;
      end
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  assign w_xfer_end = i_done_flag || w_tmo;

  // State register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) w_state_nxt = ST_XFER;
        else              w_state_nxt = ST_IDLE;
      end
      ST_XFER: begin
        if (w_xfer_end) w_state_nxt = ST_DONE;
        else            w_state_nxt = ST_XFER;
      end
      ST_DONE: w_state_nxt = ST_GAP;
      ST_GAP: begin
        if (r_gap == {GAP_W{1'b0}}) w_state_nxt = ST_IDLE;
        else                        w_state_nxt = ST_GAP;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output registers, grant bookkeeping, pointer and gap counter.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_ptr    <= {IDX_W{1'b0}};
      r_idx    <= {IDX_W{1'b0}};
      r_grant  <= {NUM_REQ{1'b0}};
      r_ack    <= {NUM_REQ{1'b0}};
      r_busy   <= 1'b0;
      r_i2c_en <= 1'b0;
      r_dev    <= {DEV_ADDR_W{1'b0}};
      r_reg    <= {DATA_W{1'b0}};
      r_wdata  <= {DATA_W{1'b0}};
      r_gap    <= {GAP_W{1'b0}};
    end else begin
      r_ack  <= {NUM_REQ{1'b0}};
      r_busy <= (w_state_nxt != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_grant  <= w_pick_grant;
            r_idx    <= w_pick_idx;
            r_dev    <= i_dev_addr[DEV_ADDR_W*w_pick_idx +: DEV_ADDR_W];
            r_reg    <= i_data_addr[DATA_W*w_pick_idx +: DATA_W];
            r_wdata  <= i_wdata[DATA_W*w_pick_idx +: DATA_W];
            r_i2c_en <= 1'b1;
          end
        end
        ST_XFER: begin
          if (w_xfer_end) begin
            r_i2c_en <= 1'b0;
            r_ack    <= r_grant;
          end
        end
        ST_DONE: begin
          r_grant <= {NUM_REQ{1'b0}};
          r_ptr   <= IDX_W'(rr_next(int'(r_idx), NUM_REQ));
          r_gap   <= GAP_W'(GAP_CYCLES - 1);
        end
        ST_GAP: begin
          if (r_gap != {GAP_W{1'b0}}) r_gap <= r_gap - GAP_W'(1);
        end
        default: begin
          r_i2c_en <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_ack         = r_ack;
  assign o_busy        = r_busy;
  assign o_i2c_en      = r_i2c_en;
  assign o_device_addr = r_dev;
  assign o_data_addr   = r_reg;
  assign o_write_data  = r_wdata;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Self-checking bench for i2c_write_arbiter: per-cycle reference model plus
// directed scenarios with hand-computed expectations.
module tb_i2c_write_arbiter;
  localparam int N   = 2;
  localparam int GAP = 16;
  localparam int TMO = 100;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [7*N-1:0] dev;
  logic [8*N-1:0] da;
  logic [8*N-1:0] wd;
  logic           done;
  logic [N-1:0]   grant, ack;
  logic           busy, en;
  logic [6:0]     o_dev;
  logic [7:0]     o_da, o_wd;
`ifdef I2C_ARB_TIMEOUT_EN
  logic           tmo_o;
`endif

  i2c_write_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         (req),
    .i_dev_addr    (dev),
    .i_data_addr   (da),
    .i_wdata       (wd),
    .o_grant       (grant),
    .o_ack         (ack),
    .o_busy        (busy),
    .o_i2c_en      (en),
    .o_device_addr (o_dev),
    .o_data_addr   (o_da),
    .o_write_data  (o_wd),
`ifdef I2C_ARB_TIMEOUT_EN
    .o_timeout     (tmo_o),
`endif
    .i_done_flag   (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return (k >= 0) ? (one << k) : {N{1'b0}};
  endfunction

  // Reference model: owner of the master, DONE flag, remaining gap cycles.
  int         m_ptr = 0, m_owner = -1, m_gap = 0, m_xcnt = 0;
  bit         m_done = 1'b0, m_to = 1'b0;
  logic [6:0] m_dev = 7'h00;
  logic [7:0] m_da = 8'h00, m_wd = 8'h00;
  bit         chk_on = 1'b0;

  always @(posedge clk) begin
    if (rst_n) begin
      m_ptr <= 0; m_owner <= -1; m_gap <= 0; m_done <= 1'b0; m_to <= 1'b0; m_xcnt <= 0;
    end else if (m_gap > 0) begin
      m_gap <= m_gap - 1;
    end else if (m_done) begin
      m_done <= 1'b0; m_to <= 1'b0;
      m_ptr <= (m_owner + 1) % N; m_owner <= -1; m_gap <= GAP;
    end else if (m_owner >= 0) begin
      if (done) m_done <= 1'b1;
      else if (TMO_EN && m_xcnt == TMO - 1) begin m_done <= 1'b1; m_to <= 1'b1; end
      else m_xcnt <= m_xcnt + 1;
    end else if (pick(req, m_ptr) >= 0) begin
      m_owner <= pick(req, m_ptr);
      m_dev   <= dev[7*pick(req, m_ptr) +: 7];
      m_da    <= da[8*pick(req, m_ptr) +: 8];
      m_wd    <= wd[8*pick(req, m_ptr) +: 8];
      m_xcnt  <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("grant", 32'(grant), 32'(oh(m_owner)));
      chk("en", 32'(en), 32'(m_owner >= 0 && !m_done));
      chk("ack", 32'(ack), 32'(m_done ? oh(m_owner) : {N{1'b0}}));
      chk("busy", 32'(busy), 32'(m_owner >= 0 || m_gap > 0));
`ifdef I2C_ARB_TIMEOUT_EN
      chk("timeout", 32'(tmo_o), 32'(m_to));
`endif
      if (m_owner >= 0 && !m_done) begin
        chk("dev", 32'(o_dev), 32'(m_dev));
        chk("reg", 32'(o_da), 32'(m_da));
        chk("wdata", 32'(o_wd), 32'(m_wd));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_en();
    int k = 0;
    while (!en && k < 300) begin step(1); k++; end
    chk("wait_en", 32'(en), 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin step(1); k++; end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  logic [N-1:0] order[$];
  logic [N-1:0] exp_order[4];
  int           k;

  initial begin
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst_n = 1'b1; req = '0; dev = '0; da = '0; wd = '0; done = 1'b0;
    step(1);
    chk_on = 1'b1;
    step(1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    rst_n = 1'b0;
    step(1);

    // Single request from requester 0, with a mid-transfer data change.
    dev[6:0] = 7'h50; da[7:0] = 8'h10; wd[7:0] = 8'hA5; req = 2'b01;
    step(1);
    chk("t1_en", 32'(en), 32'd1);
    chk("t1_dev", 32'(o_dev), 32'h50);
    chk("t1_reg", 32'(o_da), 32'h10);
    chk("t1_wd", 32'(o_wd), 32'hA5);
    step(5);
    wd[7:0] = 8'h3C;
    step(14);
    chk("t1_wd_hold", 32'(o_wd), 32'hA5);
    done = 1'b1; step(1); done = 1'b0;
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_en_drop", 32'(en), 32'd0);
    req = 2'b00;
    k = 0;
    while (k < 100) begin
      step(1);
      if (!busy) break;
      k++;
    end
    chk("t1_gap_len", 32'(k), 32'd16);

    // Reset during requester 1's transfer; the pointer must return to 0.
    dev[13:7] = 7'h21; da[15:8] = 8'h44; wd[15:8] = 8'h99; wd[7:0] = 8'hA5;
    req = 2'b11;
    step(1);
    chk("rst_pre_grant", 32'(grant), 32'h2);
    step(3);
    rst_n = 1'b1; step(1); rst_n = 1'b0;
    chk("rst_mid_grant", 32'(grant), 32'd0);
    chk("rst_mid_en", 32'(en), 32'd0);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);

    // Contention: both requesters held high for four transactions.
    for (int t = 0; t < 4; t++) begin
      wait_en();
      order.push_back(grant);
      step(3);
      done = 1'b1; step(1); done = 1'b0;
      chk("ctn_ack", 32'(ack), 32'(order[t]));
      wait_idle();
    end
    for (int t = 0; t < 4; t++) chk("ctn_order", 32'(order[t]), 32'(exp_order[t]));

    // Requester 1 drops its request mid-transfer; stray done pulses in GAP and IDLE.
    req = 2'b10;
    step(1);
    chk("drop_grant", 32'(grant), 32'h2);
    req = 2'b00;
    step(4);
    done = 1'b1; step(1); done = 1'b0;
    chk("drop_ack", 32'(ack), 32'h2);
    step(3);
    done = 1'b1; step(1); done = 1'b0;
    chk("stray_gap_ack", 32'(ack), 32'd0);
    wait_idle();
    done = 1'b1; step(1); done = 1'b0;
    chk("stray_idle_busy", 32'(busy), 32'd0);
    chk("stray_idle_ack", 32'(ack), 32'd0);
    step(2);

`ifdef I2C_ARB_TIMEOUT_EN
    // Master never completes: timeout forces DONE after TMO XFER cycles.
    req = 2'b11;
    wait_en();
    chk("tmo_first", 32'(grant), 32'h1);
    k = 0;
    while (k < 300) begin
      step(1);
      k++;
      if (ack != '0) break;
    end
    chk("tmo_cycle", 32'(k), 32'd100);
    chk("tmo_flag", 32'(tmo_o), 32'd1);
    chk("tmo_ack", 32'(ack), 32'h1);
    wait_idle();
    wait_en();
    chk("tmo_next", 32'(grant), 32'h2);
    req = 2'b00;
    done = 1'b1; step(1); done = 1'b0;
    wait_idle();
`endif

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
